// File: rtl/uart_sender_fifo.sv
// UART transmitter with an integrated bit-period divider and a TX FIFO.
// Parity mode, data width and stop-bit count are set by parameters.
module uart_sender_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          TX_DATA,
  input  logic                          TX_EN,
  output logic                          UART_TX,
  output logic                          TX_STATUS,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   TX_COUNT,
  output logic                          TX_OVF
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 ovf;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 par_calc;

  assign push     = TX_EN && (count != FULL);
  assign head     = mem[rd_ptr];
  assign par_calc = (PARITY == 2) ? ~(^head) : ^head;

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= TX_DATA;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
      if (TX_EN && !push) ovf <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Frame sequencer
  state_t               state, state_n;
  logic [DW-1:0]        div, div_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 par_bit, par_n;
  logic                 tx, tx_n;
  logic                 busy, busy_n;
  logic                 tick, load;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      par_bit <= par_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    par_n   = par_bit;
    tx_n    = tx;
    busy_n  = busy;
    load    = 1'b0;
    tick    = (div == DIV_LAST);
    if (state != S_IDLE) div_n = tick ? '0 : div + DW'(1);
    case (state)
      S_IDLE: if (count != '0) load = 1'b1;
      S_START: if (tick) begin
        state_n = S_DATA;
        tx_n    = shreg[0];
        sh_n    = shreg >> 1;
        bit_n   = '0;
      end
      S_DATA: if (tick) begin
        if (bit_cnt == DATA_LAST) begin
          bit_n = '0;
          if (PARITY != 0) begin
            state_n = S_PAR;
            tx_n    = par_bit;
          end else begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_n = bit_cnt + BW'(1);
          tx_n  = shreg[0];
          sh_n  = shreg >> 1;
        end
      end
      S_PAR: if (tick) begin
        state_n = S_STOP;
        tx_n    = 1'b1;
        bit_n   = '0;
      end
      S_STOP: if (tick) begin
        if (bit_cnt == STOP_LAST) begin
          // Chain straight into the next start bit when a word is waiting.
          if (count != '0) begin
            load = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            bit_n   = '0;
          end
        end else begin
          bit_n = bit_cnt + BW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      sh_n    = head;
      par_n   = par_calc;
      state_n = S_START;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
      div_n   = '0;
      bit_n   = '0;
    end
  end

  assign pop       = load;
  assign UART_TX   = tx;
  assign TX_BUSY   = busy;
  assign TX_COUNT  = count;
  assign TX_STATUS = (count != FULL);
  assign TX_OVF    = ovf;
endmodule

// File: tb/tb_uart_sender_fifo.sv
// Bench for uart_sender_fifo: four configurations at DIV=10, line checked bit by
// bit against frames built from the framing rules.
module tb_uart_sender_fifo;
  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] en     = '0;
  logic [7:0] dat    = '0;
  logic [3:0] tx_w, stat_w, busy_w, ovf_w;
  logic [2:0] cnt_w [4];

  int tests = 0;
  int fails = 0;
  int dbits [4] = '{8, 8, 8, 7};
  int par   [4] = '{0, 1, 2, 2};
  int stops [4] = '{1, 2, 2, 1};
  logic exp_q [$];

  always #5 sysclk = ~sysclk;

  uart_sender_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(dat), .TX_EN(en[0]), .UART_TX(tx_w[0]),
    .TX_STATUS(stat_w[0]), .TX_BUSY(busy_w[0]), .TX_COUNT(cnt_w[0]), .TX_OVF(ovf_w[0]));
  uart_sender_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) d1 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(dat), .TX_EN(en[1]), .UART_TX(tx_w[1]),
    .TX_STATUS(stat_w[1]), .TX_BUSY(busy_w[1]), .TX_COUNT(cnt_w[1]), .TX_OVF(ovf_w[1]));
  uart_sender_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) d2 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(dat), .TX_EN(en[2]), .UART_TX(tx_w[2]),
    .TX_STATUS(stat_w[2]), .TX_BUSY(busy_w[2]), .TX_COUNT(cnt_w[2]), .TX_OVF(ovf_w[2]));
  uart_sender_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d3 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(dat[6:0]), .TX_EN(en[3]), .UART_TX(tx_w[3]),
    .TX_STATUS(stat_w[3]), .TX_BUSY(busy_w[3]), .TX_COUNT(cnt_w[3]), .TX_OVF(ovf_w[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame: start, data LSB first, optional parity, stops.
  task automatic add_frame(input int s, input logic [7:0] w);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dbits[s]; i++) begin
      exp_q.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (par[s] == 1) exp_q.push_back(1'(ones % 2));
    if (par[s] == 2) exp_q.push_back(1'(1 - ones % 2));
    for (int i = 0; i < stops[s]; i++) exp_q.push_back(1'b1);
  endtask

  // Called at the negedge 'skip' cycles after the edge that dropped the line.
  task automatic check_stream(input int s, input int skip);
    int n   = exp_q.size();
    int off = skip;
    chk("busy_start", busy_w[s], 1'b1);
    for (int k = 0; k < n; k++) begin
      dat = 8'($urandom);
      repeat (10 * k + 5 - off) @(negedge sysclk);
      off = 10 * k + 5;
      chk($sformatf("d%0d_bit%0d", s, k), tx_w[s], exp_q[k]);
    end
    repeat (10 * n - 1 - off) @(negedge sysclk);
    chk("busy_last", busy_w[s], 1'b1);
    chk("line_last", tx_w[s], 1'b1);
    @(negedge sysclk);
    chk("busy_fall", busy_w[s], 1'b0);
    chk("line_idle", tx_w[s], 1'b1);
    exp_q.delete();
  endtask

  task automatic send1(input int s, input logic [7:0] w);
    dat   = w;
    en[s] = 1'b1;
    @(negedge sysclk);
    en[s] = 1'b0;
    chk("pre_fall", tx_w[s], 1'b1);
    @(negedge sysclk);
    chk("fall", tx_w[s], 1'b0);
    add_frame(s, w);
    check_stream(s, 0);
  endtask

  task automatic burst(input int s, input int n, input logic [7:0] base);
    logic [7:0] w;
    for (int i = 1; i <= n; i++) begin
      w = (base == 8'h00) ? 8'($urandom) : base + 8'(i - 1);
      if (i == 6) chk("status_full", stat_w[s], 1'b0);
      dat   = w;
      en[s] = 1'b1;
      @(negedge sysclk);
      chk($sformatf("count_%0d", i), cnt_w[s], (i == 1) ? 3'd1 : 3'((i - 1 < 4) ? i - 1 : 4));
      if (i <= 5) add_frame(s, w);
    end
    en[s] = 1'b0;
    chk("ovf", ovf_w[s], (n > 5) ? 1'b1 : 1'b0);
    check_stream(s, n - 2);
  endtask

  initial begin
    logic seen_low;
    repeat (5) @(negedge sysclk);
    chk("rst_tx", tx_w, 4'hF);
    chk("rst_busy", busy_w, 4'h0);
    chk("rst_status", stat_w, 4'hF);
    chk("rst_ovf", ovf_w, 4'h0);
    chk("rst_count", cnt_w[0], 3'd0);
    reset = 1'b0;
    seen_low = 1'b0;
    repeat (1000) begin
      @(negedge sysclk);
      if (tx_w != 4'hF || busy_w != 4'h0) seen_low = 1'b1;
    end
    chk("idle_1000", seen_low, 1'b0);

    send1(0, 8'h4A);
    send1(1, 8'h4A);
    send1(2, 8'h4A);
    send1(3, 8'h7F);
    for (int s = 0; s < 4; s++) begin
      send1(s, 8'($urandom));
      send1(s, 8'($urandom));
    end

    burst(0, 6, 8'h01);
    chk("ovf_sticky", ovf_w[0], 1'b1);
    burst(1, int'($urandom_range(2, 6)), 8'h00);

    // Abort mid-frame with two words still queued.
    dat = 8'h00; en[0] = 1'b1; @(negedge sysclk);
    dat = 8'($urandom); @(negedge sysclk);
    dat = 8'($urandom); @(negedge sysclk);
    en[0] = 1'b0;
    repeat (44) @(negedge sysclk);
    chk("mid_frame_line", tx_w[0], 1'b0);
    chk("mid_frame_count", cnt_w[0], 3'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx", tx_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_count", cnt_w[0], 3'd0);
    chk("abort_ovf", ovf_w[0], 1'b0);
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    seen_low = 1'b0;
    repeat (1000) begin
      @(negedge sysclk);
      if (tx_w[0] != 1'b1 || busy_w[0] != 1'b0 || cnt_w[0] != 3'd0) seen_low = 1'b1;
    end
    chk("post_abort_idle", seen_low, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_sender_fifo.md
Name: uart_sender_fifo

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Integrates its own bit-period divider, so no external baud clock is needed. Supports configurable data width, parity mode and stop-bit count, and buffers words in a small TX FIFO so frames go out back-to-back. Sits between the CPU peripheral bus write port and the board TX pin.

Parameters:
CLK_HZ, 100000000, sysclk frequency in Hz
BAUD, 9600, line rate; DIV = CLK_HZ/BAUD (integer truncation), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, TX FIFO entries, power of 2, >= 2

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
TX_DATA  input  DATA_BITS  word to send, sampled when TX_EN=1
TX_EN  input  1  single-cycle push strobe
UART_TX  output  1  serial line, idle high, registered
TX_STATUS  output  1  1 = FIFO not full (a push will be accepted)
TX_BUSY  output  1  1 while a frame is on the line
TX_COUNT  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
TX_OVF  output  1  sticky: a push was dropped; cleared only by reset

Behaviour:
- Reset (async, takes effect immediately, including mid-frame): UART_TX=1, TX_STATUS=1, TX_BUSY=0, TX_COUNT=0, TX_OVF=0. FIFO pointers, divider and bit counters go to 0; FSM goes to IDLE.
- Push: at an edge where TX_EN=1 and pre-edge TX_COUNT<FIFO_DEPTH, TX_DATA is written. If pre-edge count==FIFO_DEPTH, the push is dropped and TX_OVF is set. A push is dropped when full even if a pop happens on the same edge.
- TX_STATUS = (TX_COUNT != FIFO_DEPTH), decoded from the registered count.
- Simultaneous push and pop when not full: count is unchanged and both take effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: at the first edge with count>0, pop the head into the shift register, compute the parity bit, go to START, drive UART_TX=0, set TX_BUSY=1, clear the divider. The line therefore falls one cycle after the edge that wrote an empty FIFO.
- Every line bit holds exactly DIV cycles. The divider counts 0..DIV-1; the bit advances on the edge where the divider equals DIV-1.
- START -> DATA. DATA sends DATA_BITS bits LSB first, then goes to PARITY if PARITY!=0, else to STOP.
- PARITY bit: even mode = XOR of the data bits; odd mode = its inverse.
- STOP: line high for STOP_BITS*DIV cycles. At the last stop edge: if count>0, pop and enter START directly (no idle gap); else go to IDLE with TX_BUSY=0.
- Frame length = 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS bit times.
- TX_DATA/TX_EN activity during a frame never disturbs the frame in flight; the word was captured at pop.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame aborts the frame and discards all queued data; no frame starts until a push follows reset release.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000, so DIV=10.
1. Assert reset for 5 cycles, then release -> UART_TX=1, TX_STATUS=1, TX_BUSY=0, TX_COUNT=0, TX_OVF=0; line stays high for 1000 cycles with no push.
2. Defaults (8N1): push 8'h4A -> line falls 1 cycle after the push edge and shows 0,0,1,0,1,0,0,1,0,1 (start, LSB first, stop), 10 cycles each; TX_BUSY deasserts exactly 100 cycles after it rose.
3. PARITY=1, STOP_BITS=2: push 8'h4A -> parity bit 1 after the data bits, then 20 cycles high, frame 120 cycles. PARITY=2 -> parity bit 0.
4. FIFO_DEPTH=4, idle, push 6 words 8'h01..8'h06 on consecutive cycles:
   - TX_COUNT sequence 1,1,2,3,4,4.
   - 6th push dropped: TX_STATUS=0 at that edge, TX_OVF=1.
   - 8'h01..8'h05 go out as 5 contiguous frames over 500 cycles with no high gap between stop and next start.
   - TX_OVF stays 1 afterwards.
5. Assert reset during data bit 3 of a frame with 2 words queued -> UART_TX=1 before the next sysclk edge, TX_COUNT=0, TX_BUSY=0; no frame appears within 1000 cycles after release.
6. DATA_BITS=7, PARITY=2: push 7'h7F -> 7 ones, parity 0, 1 stop bit; frame 100 cycles; upper FIFO bits are never sent.
